// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker for the 8-bit LFSR pattern generator.
// It seeds a local reference from 8 received bits, then predicts every
// following bit from the reference alone, flags mismatches and counts them.
module lfsr_prbs_checker #(
  parameter int ERR_CNT_W   = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sequence_bit,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] bit_count
);

  typedef enum logic {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]           SEED_LEN = 4'd8;
  localparam logic [3:0]           LOSS_LIM = 4'(LOSS_THRESH);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ZERO = {ERR_CNT_W{1'b0}};

  // Generator feedback: parity of taps 7,6,3,2,1,0.
  function automatic logic prbs_fb(input logic [7:0] s);
    return s[7] ^ s[6] ^ s[3] ^ s[2] ^ s[1] ^ s[0];
  endfunction

  state_t               state_r;
  logic [7:0]           ref_r;
  logic [3:0]           seed_cnt_r;
  logic [3:0]           consec_err_r;
  logic                 locked_r;
  logic                 error_r;
  logic [ERR_CNT_W-1:0] err_count_r;
  logic [ERR_CNT_W-1:0] bit_count_r;

  logic                 pred_s;
  logic                 mismatch_s;
  logic [7:0]           seed_ref_s;
  logic [7:0]           pred_ref_s;
  logic [3:0]           seed_cnt_nxt_s;
  logic [3:0]           consec_nxt_s;
  logic [ERR_CNT_W-1:0] err_cnt_inc_s;
  logic [ERR_CNT_W-1:0] bit_cnt_inc_s;

  // Next-bit prediction, candidate reference values and saturating increments.
  always_comb begin
    pred_s     = prbs_fb(ref_r);
    mismatch_s = sequence_bit ^ pred_s;
    seed_ref_s = {ref_r[6:0], sequence_bit};
    pred_ref_s = {ref_r[6:0], pred_s};
    if (seed_cnt_r == SEED_LEN) begin
      seed_cnt_nxt_s = SEED_LEN;
    end else begin
      seed_cnt_nxt_s = seed_cnt_r + 4'd1;
    end
    consec_nxt_s = consec_err_r + 4'd1;
    if (err_count_r == CNT_MAX) begin
      err_cnt_inc_s = CNT_MAX;
    end else begin
      err_cnt_inc_s = err_count_r + CNT_ONE;
    end
    if (bit_count_r == CNT_MAX) begin
      bit_cnt_inc_s = CNT_MAX;
    end else begin
      bit_cnt_inc_s = bit_count_r + CNT_ONE;
    end
  end

  // Seed/lock state machine with registered status, pulse and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= SEED;
      ref_r        <= 8'h00;
      seed_cnt_r   <= 4'd0;
      consec_err_r <= 4'd0;
      locked_r     <= 1'b0;
      error_r      <= 1'b0;
      err_count_r  <= CNT_ZERO;
      bit_count_r  <= CNT_ZERO;
    end else begin
      error_r <= 1'b0;
      if (enable) begin
        case (state_r)
          SEED: begin
            // All-zero is the generator's stuck state, so keep sliding.
            ref_r      <= seed_ref_s;
            seed_cnt_r <= seed_cnt_nxt_s;
            if ((seed_cnt_nxt_s == SEED_LEN) && (seed_ref_s != 8'h00)) begin
              state_r      <= LOCKED;
              locked_r     <= 1'b1;
              consec_err_r <= 4'd0;
            end else begin
              state_r  <= SEED;
              locked_r <= 1'b0;
            end
          end
          LOCKED: begin
            // Shift in the prediction so a bad bit never corrupts the reference.
            ref_r       <= pred_ref_s;
            bit_count_r <= bit_cnt_inc_s;
            if (mismatch_s) begin
              err_count_r <= err_cnt_inc_s;
              error_r     <= 1'b1;
              if (consec_nxt_s == LOSS_LIM) begin
                state_r      <= SEED;
                locked_r     <= 1'b0;
                seed_cnt_r   <= 4'd0;
                consec_err_r <= 4'd0;
              end else begin
                consec_err_r <= consec_nxt_s;
              end
            end else begin
              consec_err_r <= 4'd0;
            end
          end
          default: begin
            state_r      <= SEED;
            locked_r     <= 1'b0;
            seed_cnt_r   <= 4'd0;
            consec_err_r <= 4'd0;
          end
        endcase
      end
      // Clear wins over any same-cycle increment.
      if (clear) begin
        err_count_r <= CNT_ZERO;
        bit_count_r <= CNT_ZERO;
      end
    end
  end

  assign locked    = locked_r;
  assign error     = error_r;
  assign err_count = err_count_r;
  assign bit_count = bit_count_r;

endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

Self-synchronising checker for the serial output of the 8-bit LFSR pattern generator. It sits directly downstream of the generator, sampling one bit per enabled cycle. It seeds a local copy of the generator state from the received bits, then predicts and compares every following bit, flagging mismatches and counting them. Used for link and loopback bit-error testing.

## Interface
- ERR_CNT_W, 16, width of the saturating error and checked-bit counters
- LOSS_THRESH, 4, number of consecutive mismatches in LOCKED that drops lock (1..15)

- clk  input  1  single clock; all logic is rising-edge
- rst  input  1  one clock; reset is asynchronous and active-low
- enable  input  1  bit-valid strobe, driven by the same enable that steps the generator
- sequence  input  1  received serial bit; sampled only when enable=1
- clear  input  1  synchronous clear of err_count and bit_count
- locked  output  1  high while in LOCKED
- error  output  1  one-cycle pulse per mismatched bit
- err_count  output  ERR_CNT_W  saturating count of mismatches since reset or clear
- bit_count  output  ERR_CNT_W  saturating count of bits compared in LOCKED

## Operation
- Polynomial: the generator shifts left and inserts fb = s[7]^s[6]^s[3]^s[2]^s[1]^s[0] at bit 0. Its output is s[0]. After 8 consecutive outputs, the generator state equals the last 8 received bits, with the newest bit in bit 0.
- Internal state: 8-bit ref register r, 4-bit seed_cnt, 4-bit consec_err, FSM {SEED, LOCKED}.
- SEED, on each enable:
  - r <= {r[6:0], sequence}.
  - seed_cnt increments, saturating at 8.
  - When seed_cnt reaches 8 and the updated r is non-zero, move to LOCKED.
  - All-zero r: stay in SEED and keep sliding, since all-zero is the generator's stuck state.
- LOCKED, on each enable:
  - p = parity(r[7],r[6],r[3],r[2],r[1],r[0]).
  - r <= {r[6:0], p}. The predicted bit is shifted in, not the received bit, so errors do not propagate.
  - mismatch = sequence ^ p.
  - bit_count increments, saturating.
  - On mismatch: err_count increments (saturating at all-ones), error pulses, consec_err increments.
  - On match: consec_err <= 0.
  - When consec_err reaches LOSS_THRESH, go to SEED with seed_cnt=0 and consec_err=0. r keeps shifting in received bits from the next enable.
- enable=0: no state change, error=0.
- clear=1: err_count and bit_count go to 0. This takes priority over a same-cycle increment. FSM, r and lock state are unaffected.
- Counters are never cleared by loss of lock.

## Timing
- Reset (rst=0, asynchronous): FSM=SEED, r=0, seed_cnt=0, consec_err=0, locked=0, error=0, err_count=0, bit_count=0. Release is synchronous to clk.
- All outputs are registered. They reflect the bit sampled at edge N from cycle N+1 onward.
- locked rises the cycle after the edge that samples the 8th valid bit, given a non-zero seed.
- The first comparison is made on the 9th valid bit.
- error is high for exactly one cycle per mismatched enabled bit. Back-to-back mismatches give back-to-back pulses.
- Lock loss: locked falls the cycle after the edge that samples the LOSS_THRESH-th consecutive mismatch. That mismatch is still counted and pulsed.
- Relock needs 8 further valid bits, with gaps in enable allowed.
- rst asserted mid-LOCKED: all outputs drop immediately, without waiting for clk.

## Test plan
- Generator loaded 8'hA5 then enabled for 100 cycles, enable tied to the checker -> locked=1 from cycle 9, error never asserts, err_count=0, bit_count=92.
- Same stream with bit 40 inverted -> exactly one error pulse (cycle after bit 40), err_count=1, locked stays 1, bit_count=92.
- Same stream with bits 40-43 inverted -> 4 error pulses, err_count=4, locked falls after bit 43, rises again after bit 51, no errors afterwards.
- 20 zero bits from a generator loaded 8'h00 -> locked stays 0, err_count=0, bit_count=0. Then reset the generator, load 8'h01 and run -> locks.
- Random enable gaps (about 50% duty) on an 8'h3C stream -> identical counts to the gapless run. error and counters change only on enabled cycles.
- While locked with err_count=3: clear asserted in the same cycle as a mismatch -> err_count=0 and bit_count=0 next cycle, error still pulses. Then rst asserted mid-stream -> all outputs 0 asynchronously, and relock takes 8 bits after release.
